// File: rtl/bsg_mcl_gearbox_pkg.sv
`default_nettype none
// ============================================================================
// Package : bsg_mcl_gearbox_pkg
// Brief   : Shared width helpers for the manycore-link word/packet gearbox.
// Rev     : 1.0 - initial release
// ============================================================================
package bsg_mcl_gearbox_pkg;

  function automatic int words_f(input int fifo_width, input int word_width);
    return fifo_width / word_width;
  endfunction

  // Index registers stay at least one bit wide even for single-word packets
  function automatic int idx_width_f(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int count_width_f(input int els, input int words);
    return $clog2(els * words + 1);
  endfunction

  localparam int default_words_lp = words_f(128, 32);

  typedef logic [idx_width_f(default_words_lp)-1:0] word_idx_t;

endpackage
`default_nettype wire

// File: rtl/bsg_counter_up_down.sv
`default_nettype none
// ============================================================================
// Module : bsg_counter_up_down
// Brief  : Saturation-checked up/down occupancy counter.
// Rev    : 1.0 - initial release
// ============================================================================
module bsg_counter_up_down #(
  parameter int max_val_p = 4,
  parameter int width_p   = $clog2(max_val_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [width_p-1:0] count_o
);

  logic [width_p-1:0] r_count;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_count <= '0;
    end else if (up_i && !down_i) begin
      r_count <= r_count + width_p'(1);
    end else if (down_i && !up_i) begin
      r_count <= r_count - width_p'(1);
    end
  end

  assign count_o = r_count;

  a_no_overflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(up_i && !down_i && (r_count == width_p'(max_val_p))));
  a_no_underflow: assert property (@(posedge clk_i) disable iff (reset_i)
    !(down_i && !up_i && (r_count == '0)));

endmodule
`default_nettype wire

// File: rtl/bsg_fifo_1r1w_small.sv
`default_nettype none
// ============================================================================
// Module : bsg_fifo_1r1w_small
// Brief  : Small register-array FIFO; head valid the cycle after enqueue.
// Rev    : 1.0 - initial release
// ============================================================================
module bsg_fifo_1r1w_small import bsg_mcl_gearbox_pkg::*; #(
  parameter  int width_p   = 128,
  parameter  int els_p     = 4,
  localparam int ptr_w_lp  = idx_width_f(els_p),
  localparam int cnt_w_lp  = $clog2(els_p + 1)
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                enq_i,
  input  logic [width_p-1:0]  data_i,
  output logic                full_o,
  input  logic                deq_i,
  output logic                v_o,
  output logic [width_p-1:0]  data_o,
  output logic [cnt_w_lp-1:0] count_o
);

  logic [width_p-1:0]  r_mem [els_p];
  logic [ptr_w_lp-1:0] r_wr_ptr;
  logic [ptr_w_lp-1:0] r_rd_ptr;
  logic [cnt_w_lp-1:0] w_count;

  always_ff @(posedge clk_i) begin
    if (enq_i) begin
      r_mem[r_wr_ptr] <= data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (enq_i) begin
        r_wr_ptr <= (r_wr_ptr == ptr_w_lp'(els_p - 1)) ? '0 : r_wr_ptr + ptr_w_lp'(1);
      end
      if (deq_i) begin
        r_rd_ptr <= (r_rd_ptr == ptr_w_lp'(els_p - 1)) ? '0 : r_rd_ptr + ptr_w_lp'(1);
      end
    end
  end

  bsg_counter_up_down #(
    .max_val_p (els_p),
    .width_p   (cnt_w_lp)
  ) u_count (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .up_i    (enq_i),
    .down_i  (deq_i),
    .count_o (w_count)
  );

  // Full/empty come from registered state only, so no enq->rdy bypass exists
  assign full_o  = (w_count == cnt_w_lp'(els_p));
  assign v_o     = (w_count != '0);
  assign data_o  = r_mem[r_rd_ptr];
  assign count_o = w_count;

  a_no_enq_full: assert property (@(posedge clk_i) disable iff (reset_i) enq_i |-> !full_o);
  a_no_deq_empty: assert property (@(posedge clk_i) disable iff (reset_i) deq_i |-> v_o);

endmodule
`default_nettype wire

// File: rtl/bsg_mcl_fifo_word_gearbox_unpacker.sv
`default_nettype none
// ============================================================================
// Module : bsg_mcl_word_unpacker
// Brief  : RX packet buffer served back one host word at a time, word 0 first.
// Rev    : 1.0 - initial release
// ============================================================================
module bsg_mcl_word_unpacker import bsg_mcl_gearbox_pkg::*; #(
  parameter  int fifo_width_p = 128,
  parameter  int word_width_p = 32,
  parameter  int els_p        = 4,
  localparam int words_lp     = words_f(fifo_width_p, word_width_p),
  localparam int idx_w_lp     = idx_width_f(words_lp),
  localparam int pkt_w_lp     = $clog2(els_p + 1),
  localparam int occ_w_lp     = count_width_f(els_p, words_lp)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    fifo_v_i,
  input  logic [fifo_width_p-1:0] fifo_data_i,
  output logic                    fifo_rdy_o,
  output logic                    word_v_o,
  output logic [word_width_p-1:0] word_o,
  input  logic                    word_rdy_i,
  output logic [occ_w_lp-1:0]     occupancy_o
);

  logic                    w_full;
  logic                    w_enq;
  logic                    w_take;
  logic                    w_last;
  logic                    w_deq;
  logic [fifo_width_p-1:0] w_head;
  logic [pkt_w_lp-1:0]     w_pkts;
  logic [idx_w_lp-1:0]     r_idx;

  assign fifo_rdy_o = !w_full;
  assign w_enq      = fifo_v_i && !w_full;
  assign w_take     = word_v_o && word_rdy_i;
  assign w_last     = (r_idx == idx_w_lp'(words_lp - 1));
  assign w_deq      = w_take && w_last;

  bsg_fifo_1r1w_small #(
    .width_p (fifo_width_p),
    .els_p   (els_p)
  ) u_rx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (w_enq),
    .data_i  (fifo_data_i),
    .full_o  (w_full),
    .deq_i   (w_deq),
    .v_o     (word_v_o),
    .data_o  (w_head),
    .count_o (w_pkts)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_idx <= '0;
    end else if (w_take) begin
      r_idx <= w_last ? '0 : r_idx + idx_w_lp'(1);
    end
  end

  assign word_o      = w_head[int'(r_idx) * word_width_p +: word_width_p];
  assign occupancy_o = occ_w_lp'(32'(w_pkts) * 32'(words_lp) - 32'(r_idx));

  // A nonzero index with no packet buffered would make the occupancy wrap
  a_idx_needs_pkt: assert property (@(posedge clk_i) disable iff (reset_i)
    (w_pkts != '0) || (r_idx == '0));
  a_occ_max: assert property (@(posedge clk_i) disable iff (reset_i)
    occupancy_o <= occ_w_lp'(els_p * words_lp));

endmodule
`default_nettype wire

// File: rtl/bsg_mcl_fifo_word_gearbox.sv
`default_nettype none
// ============================================================================
// Module : bsg_mcl_fifo_word_gearbox
// Brief  : 32-bit host word <-> 128-bit manycore-link packet gearbox, TX + RX.
// Rev    : 1.0 - initial release
// ============================================================================
module bsg_mcl_fifo_word_gearbox import bsg_mcl_gearbox_pkg::*; #(
  parameter  int fifo_width_p = 128,
  parameter  int word_width_p = 32,
  parameter  int tx_els_p     = 4,
  parameter  int rx_els_p     = 4,
  localparam int words_lp     = words_f(fifo_width_p, word_width_p),
  localparam int cnt_w_lp     = idx_width_f(words_lp),
  localparam int tx_pkt_w_lp  = $clog2(tx_els_p + 1),
  localparam int tx_vac_w_lp  = count_width_f(tx_els_p, words_lp),
  localparam int rx_occ_w_lp  = count_width_f(rx_els_p, words_lp)
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    tx_word_v_i,
  input  logic [word_width_p-1:0] tx_word_i,
  output logic                    tx_word_rdy_o,
  output logic                    fifo_v_o,
  output logic [fifo_width_p-1:0] fifo_data_o,
  input  logic                    fifo_rdy_i,
  input  logic                    fifo_v_i,
  input  logic [fifo_width_p-1:0] fifo_data_i,
  output logic                    fifo_rdy_o,
  output logic                    rx_word_v_o,
  output logic [word_width_p-1:0] rx_word_o,
  input  logic                    rx_word_rdy_i,
  output logic [tx_vac_w_lp-1:0]  tx_vacancy_o,
  output logic [rx_occ_w_lp-1:0]  rx_occupancy_o
);

  logic [cnt_w_lp-1:0]     r_tx_cnt;
  logic [fifo_width_p-1:0] r_tx_asm;
  logic [fifo_width_p-1:0] w_tx_pkt;
  logic                    w_tx_last;
  logic                    w_tx_acc;
  logic                    w_tx_enq;
  logic                    w_tx_deq;
  logic                    w_tx_full;
  logic [tx_pkt_w_lp-1:0]  w_tx_pkts;
  logic [31:0]             w_tx_slots;

  assign w_tx_last     = (r_tx_cnt == cnt_w_lp'(words_lp - 1));
  assign tx_word_rdy_o = !(w_tx_last && w_tx_full);
  assign w_tx_acc      = tx_word_v_i && tx_word_rdy_o;
  assign w_tx_enq      = w_tx_acc && w_tx_last;
  assign w_tx_deq      = fifo_v_o && fifo_rdy_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_tx_cnt <= '0;
    end else if (w_tx_acc) begin
      r_tx_cnt <= w_tx_last ? '0 : r_tx_cnt + cnt_w_lp'(1);
    end
  end

  // Assembly contents are don't-care after reset; r_tx_cnt alone tracks validity
  always_ff @(posedge clk_i) begin
    if (w_tx_acc) begin
      r_tx_asm[int'(r_tx_cnt) * word_width_p +: word_width_p] <= tx_word_i;
    end
  end

  always_comb begin
    w_tx_pkt = r_tx_asm;
    w_tx_pkt[(words_lp - 1) * word_width_p +: word_width_p] = tx_word_i;
  end

  bsg_fifo_1r1w_small #(
    .width_p (fifo_width_p),
    .els_p   (tx_els_p)
  ) u_tx_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .enq_i   (w_tx_enq),
    .data_i  (w_tx_pkt),
    .full_o  (w_tx_full),
    .deq_i   (w_tx_deq),
    .v_o     (fifo_v_o),
    .data_o  (fifo_data_o),
    .count_o (w_tx_pkts)
  );

  // Words parked in the assembly register while the buffer is full would take
  // the raw difference below zero; report no vacancy in that case instead.
  assign w_tx_slots   = (32'(tx_els_p) - 32'(w_tx_pkts)) * 32'(words_lp);
  assign tx_vacancy_o = (w_tx_slots > 32'(r_tx_cnt))
                      ? tx_vac_w_lp'(w_tx_slots - 32'(r_tx_cnt)) : '0;

  bsg_mcl_word_unpacker #(
    .fifo_width_p (fifo_width_p),
    .word_width_p (word_width_p),
    .els_p        (rx_els_p)
  ) u_rx (
    .clk_i       (clk_i),
    .reset_i     (reset_i),
    .fifo_v_i    (fifo_v_i),
    .fifo_data_i (fifo_data_i),
    .fifo_rdy_o  (fifo_rdy_o),
    .word_v_o    (rx_word_v_o),
    .word_o      (rx_word_o),
    .word_rdy_i  (rx_word_rdy_i),
    .occupancy_o (rx_occupancy_o)
  );

  a_width_multiple: assert property (@(posedge clk_i) (fifo_width_p % word_width_p) == 0);
  a_tx_vac_max: assert property (@(posedge clk_i) disable iff (reset_i)
    tx_vacancy_o <= tx_vac_w_lp'(tx_els_p * words_lp));

endmodule
`default_nettype wire

// File: tb/tb_bsg_mcl_fifo_word_gearbox.sv
`default_nettype none
// ============================================================================
// Module : tb_bsg_mcl_fifo_word_gearbox
// Brief  : Scoreboard bench for the word/packet gearbox, TX and RX paths.
// Rev    : 1.0 - initial release
// ============================================================================
module tb_bsg_mcl_fifo_word_gearbox;

  logic         clk_i = 1'b0;
  logic         reset_i;
  logic         tx_word_v_i;
  logic [31:0]  tx_word_i;
  logic         tx_word_rdy_o;
  logic         fifo_v_o;
  logic [127:0] fifo_data_o;
  logic         fifo_rdy_i;
  logic         fifo_v_i;
  logic [127:0] fifo_data_i;
  logic         fifo_rdy_o;
  logic         rx_word_v_o;
  logic [31:0]  rx_word_o;
  logic         rx_word_rdy_i;
  logic [4:0]   tx_vacancy_o;
  logic [4:0]   rx_occupancy_o;

  always #5 clk_i = ~clk_i;

  bsg_mcl_fifo_word_gearbox dut (
    .clk_i          (clk_i),
    .reset_i        (reset_i),
    .tx_word_v_i    (tx_word_v_i),
    .tx_word_i      (tx_word_i),
    .tx_word_rdy_o  (tx_word_rdy_o),
    .fifo_v_o       (fifo_v_o),
    .fifo_data_o    (fifo_data_o),
    .fifo_rdy_i     (fifo_rdy_i),
    .fifo_v_i       (fifo_v_i),
    .fifo_data_i    (fifo_data_i),
    .fifo_rdy_o     (fifo_rdy_o),
    .rx_word_v_o    (rx_word_v_o),
    .rx_word_o      (rx_word_o),
    .rx_word_rdy_i  (rx_word_rdy_i),
    .tx_vacancy_o   (tx_vacancy_o),
    .rx_occupancy_o (rx_occupancy_o)
  );

  int           n_checks = 0;
  int           n_fail   = 0;
  int           cyc      = 0;
  logic [127:0] tx_exp_q [$];
  logic [31:0]  rx_exp_q [$];
  logic [127:0] tb_asm;
  int           tb_idx;
  bit           rand_on;

  always @(posedge clk_i) cyc++;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference packer: little-endian, word 0 in the low bits
  task automatic expect_word(input logic [31:0] w);
    tb_asm[tb_idx*32 +: 32] = w;
    tb_idx++;
    if (tb_idx == 4) begin
      tx_exp_q.push_back(tb_asm);
      tb_idx = 0;
    end
  endtask

  task automatic tx_send(input logic [31:0] w);
    int t = 0;
    tx_word_v_i = 1'b1;
    tx_word_i   = w;
    @(negedge clk_i);
    while (!tx_word_rdy_o && t < 500) begin
      t++;
      @(negedge clk_i);
    end
    if (t >= 500) check("tx_rdy_timeout", 128'(tx_word_rdy_o), 128'd1);
    @(posedge clk_i);
    #1;
    tx_word_v_i = 1'b0;
    expect_word(w);
  endtask

  task automatic rx_push(input logic [127:0] pkt);
    int t = 0;
    fifo_v_i    = 1'b1;
    fifo_data_i = pkt;
    @(negedge clk_i);
    while (!fifo_rdy_o && t < 500) begin
      t++;
      @(negedge clk_i);
    end
    if (t >= 500) check("rx_rdy_timeout", 128'(fifo_rdy_o), 128'd1);
    @(posedge clk_i);
    #1;
    fifo_v_i = 1'b0;
    for (int k = 0; k < 4; k++) rx_exp_q.push_back(pkt[k*32 +: 32]);
  endtask

  task automatic rx_read_one();
    rx_word_rdy_i = 1'b1;
    @(posedge clk_i);
    #1;
    rx_word_rdy_i = 1'b0;
  endtask

  task automatic drain_all();
    int t = 0;
    @(negedge clk_i);
    while ((fifo_v_o || rx_word_v_o) && t < 200) begin
      t++;
      @(negedge clk_i);
    end
    check("drain_tx_v", 128'(fifo_v_o), 128'd0);
    check("drain_rx_v", 128'(rx_word_v_o), 128'd0);
    @(posedge clk_i);
    #1;
  endtask

  // Monitors: compare every handshake against the scoreboard queues
  always @(negedge clk_i) begin
    if (!reset_i && fifo_v_o && fifo_rdy_i) begin
      if (tx_exp_q.size() == 0) check("tx_unexpected_pkt", 128'(fifo_v_o), 128'd0);
      else check("tx_pkt", fifo_data_o, tx_exp_q.pop_front());
    end
    if (!reset_i && rx_word_v_o && rx_word_rdy_i) begin
      if (rx_exp_q.size() == 0) check("rx_unexpected_word", 128'(rx_word_v_o), 128'd0);
      else check("rx_word", 128'(rx_word_o), 128'(rx_exp_q.pop_front()));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] pk;
    int           c0;
    int           n;

    reset_i       = 1'b1;
    tx_word_v_i   = 1'b0;
    tx_word_i     = '0;
    fifo_rdy_i    = 1'b0;
    fifo_v_i      = 1'b0;
    fifo_data_i   = '0;
    rx_word_rdy_i = 1'b0;
    tb_idx        = 0;
    tb_asm        = '0;
    repeat (3) @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    @(negedge clk_i);
    check("rst_tx_rdy",  128'(tx_word_rdy_o),  128'd1);
    check("rst_fifo_v",  128'(fifo_v_o),       128'd0);
    check("rst_fifo_rdy",128'(fifo_rdy_o),     128'd1);
    check("rst_rx_v",    128'(rx_word_v_o),    128'd0);
    check("rst_tx_vac",  128'(tx_vacancy_o),   128'd16);
    check("rst_rx_occ",  128'(rx_occupancy_o), 128'd0);

    // Basic packing and one-cycle enqueue-to-valid latency
    @(posedge clk_i);
    #1;
    fifo_rdy_i = 1'b1;
    tx_send(32'h11);
    tx_send(32'h22);
    tx_send(32'h33);
    tx_send(32'h44);
    @(negedge clk_i);
    check("t1_fifo_v",    128'(fifo_v_o), 128'd1);
    check("t1_fifo_data", fifo_data_o, 128'h00000044_00000033_00000022_00000011);
    @(posedge clk_i);
    #1;
    check("t1_fifo_v_after", 128'(fifo_v_o), 128'd0);
    check("t1_vac",          128'(tx_vacancy_o), 128'd16);

    // Fill TX with the bridge stalled, hold the last word, then release
    fifo_rdy_i = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      tx_send(32'h0200_0000 + i);
      if (i == 6) check("t2_vac6", 128'(tx_vacancy_o), 128'd10);
    end
    check("t2_vac16", 128'(tx_vacancy_o), 128'd0);
    for (int i = 17; i <= 19; i++) tx_send(32'h0200_0000 + i);
    check("t2_vac19",      128'(tx_vacancy_o),  128'd0);
    check("t2_rdy_held",   128'(tx_word_rdy_o), 128'd0);
    tx_word_v_i = 1'b1;
    tx_word_i   = 32'h0200_0014;
    @(negedge clk_i);
    check("t2_rdy_held2",  128'(tx_word_rdy_o), 128'd0);
    @(posedge clk_i);
    #1;
    fifo_rdy_i = 1'b1;
    @(negedge clk_i);
    check("t2_no_bypass",  128'(tx_word_rdy_o), 128'd0);
    @(posedge clk_i);
    #1;
    @(negedge clk_i);
    check("t2_rdy_after_deq", 128'(tx_word_rdy_o), 128'd1);
    @(posedge clk_i);
    #1;
    tx_word_v_i = 1'b0;
    expect_word(32'h0200_0014);
    drain_all();
    check("t2_vac_drained", 128'(tx_vacancy_o),    128'd16);
    check("t2_all_pkts",    128'(tx_exp_q.size()), 128'd0);

    // RX word serving with occupancy countdown
    rx_word_rdy_i = 1'b1;
    rx_push(128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA);
    for (int i = 0; i <= 4; i++) begin
      @(negedge clk_i);
      check($sformatf("t3_occ%0d", i), 128'(rx_occupancy_o), 128'(4 - i));
      check($sformatf("t3_v%0d", i),   128'(rx_word_v_o),    128'((i < 4) ? 1 : 0));
      @(posedge clk_i);
      #1;
    end

    // RX full, then partial reads keep it full until the head packet retires
    rx_word_rdy_i = 1'b0;
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++) pk[k*32 +: 32] = 32'h0400_0000 + 32'(p*16 + k);
      rx_push(pk);
    end
    check("t4_full_rdy", 128'(fifo_rdy_o),     128'd0);
    check("t4_occ16",    128'(rx_occupancy_o), 128'd16);
    rx_read_one();
    check("t4_occ15",    128'(rx_occupancy_o), 128'd15);
    check("t4_rdy1",     128'(fifo_rdy_o),     128'd0);
    rx_read_one();
    rx_read_one();
    check("t4_occ13",    128'(rx_occupancy_o), 128'd13);
    check("t4_rdy3",     128'(fifo_rdy_o),     128'd0);
    rx_read_one();
    check("t4_occ12",    128'(rx_occupancy_o), 128'd12);
    check("t4_rdy4",     128'(fifo_rdy_o),     128'd1);
    rx_word_rdy_i = 1'b1;
    drain_all();
    check("t4_rx_all", 128'(rx_exp_q.size()), 128'd0);

    // Reset mid-packet discards the partial assembly
    tx_send(32'h0500_0001);
    tx_send(32'h0500_0002);
    check("t5_vac14", 128'(tx_vacancy_o), 128'd14);
    reset_i = 1'b1;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;
    tb_idx  = 0;
    check("t5_vac_rst",  128'(tx_vacancy_o),   128'd16);
    check("t5_fifo_v",   128'(fifo_v_o),       128'd0);
    check("t5_rx_occ",   128'(rx_occupancy_o), 128'd0);
    for (int i = 1; i <= 4; i++) tx_send(32'h0600_0000 + i);
    drain_all();
    check("t5_single_pkt", 128'(tx_exp_q.size()), 128'd0);

    // Concurrent traffic on both paths with random backpressure
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          fifo_rdy_i    = 1'($urandom_range(0, 1));
          rx_word_rdy_i = 1'($urandom_range(0, 1));
          @(posedge clk_i);
          #1;
        end
      end
    join_none
    fork
      begin
        for (int i = 0; i < 32; i++) tx_send(32'h0700_0000 + i);
      end
      begin
        logic [127:0] rp;
        for (int p = 0; p < 6; p++) begin
          for (int k = 0; k < 4; k++) rp[k*32 +: 32] = 32'h0800_0000 + 32'(p*16 + k);
          rx_push(rp);
        end
      end
    join
    rand_on = 1'b0;
    @(posedge clk_i);
    #1;
    fifo_rdy_i    = 1'b1;
    rx_word_rdy_i = 1'b1;
    drain_all();
    check("t6_tx_all", 128'(tx_exp_q.size()), 128'd0);
    check("t6_rx_all", 128'(rx_exp_q.size()), 128'd0);

    // Full rate with ready tied high
    c0 = cyc;
    for (int i = 0; i < 8; i++) tx_send(32'h0900_0000 + i);
    check("t7_tx_rate", 128'(cyc - c0), 128'd8);
    rx_push(128'h0A000003_0A000002_0A000001_0A000000);
    rx_push(128'h0A000007_0A000006_0A000005_0A000004);
    n = 0;
    @(negedge clk_i);
    while (rx_word_v_o && n < 50) begin
      n++;
      @(negedge clk_i);
    end
    check("t7_rx_rate", 128'(n), 128'd7);
    @(posedge clk_i);
    #1;
    drain_all();
    check("end_tx_q", 128'(tx_exp_q.size()), 128'd0);
    check("end_rx_q", 128'(rx_exp_q.size()), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
